// File: rtl/unidad_aritmetica_seq_if.sv
// unidad_aritmetica_seq_if: operand/opcode request and result bus of the arithmetic unit.
// Revision 1.0
`default_nettype none

interface unidad_aritmetica_seq_if #(
  parameter int ANCHO = 32
);
  logic [ANCHO-1:0] datoA;
  logic [ANCHO-1:0] datoB;
  logic [2:0]       operacion;
  logic             start;
  logic [ANCHO-1:0] resultado;
  logic             ready;
  logic             error;

  modport master (
    output datoA, datoB, operacion, start,
    input  resultado, ready, error
  );

  modport slave (
    input  datoA, datoB, operacion, start,
    output resultado, ready, error
  );
endinterface

`default_nettype wire

// File: rtl/unidad_aritmetica_seq.sv
// unidad_aritmetica_seq: multi-cycle unsigned add/sub/mul/div unit; opcode 4 (remainder)
// exists only when CALC_MODULO_EN is defined. Revision 1.0
`default_nettype none

module unidad_aritmetica_seq #(
  parameter int ANCHO = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  unidad_aritmetica_seq_if.slave  bus
);

  localparam int             CW       = $clog2(ANCHO);
  localparam logic [CW-1:0]  c_ULTIMO = CW'(ANCHO - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_SUMA  = 3'd0;
  localparam logic [2:0] OP_RESTA = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;

  logic [1:0]         state_q, state_d;
  logic [ANCHO-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*ANCHO-1:0] acc_q, acc_d;
  logic [ANCHO-1:0]   res_q, res_d;
  logic               ready_q, ready_d;
  logic               error_q, error_d;

  logic               w_es_mod, w_es_div, w_es_mul, w_div_cero, w_iterativa, w_fin;
  logic [ANCHO-1:0]   w_hi, w_lo;
  logic [ANCHO:0]     w_mul_suma, w_div_parcial, w_div_resta, w_suma;
  logic [2*ANCHO-1:0] w_mul_paso, w_div_paso, w_paso;
  logic [ANCHO-1:0]   w_val, w_res_fin;
  logic               w_err;

`ifdef CALC_MODULO_EN
  assign w_es_mod = (op_q == 3'd4);
`else
  assign w_es_mod = 1'b0;
`endif

  assign w_es_mul    = (op_q == OP_MUL);
  assign w_es_div    = (op_q == OP_DIV) || w_es_mod;
  assign w_div_cero  = w_es_div && (b_q == '0);
  assign w_iterativa = (w_es_mul || w_es_div) && !w_div_cero;
  assign w_fin       = !w_iterativa || (cnt_q == c_ULTIMO);

  // acc holds {high, low}: {partial product, multiplier} or {remainder, quotient}
  assign w_hi = acc_q[2*ANCHO-1:ANCHO];
  assign w_lo = acc_q[ANCHO-1:0];

  assign w_mul_suma = {1'b0, w_hi} + {1'b0, (w_lo[0] ? a_q : '0)};
  assign w_mul_paso = {w_mul_suma, w_lo[ANCHO-1:1]};

  assign w_div_parcial = {w_hi, w_lo[ANCHO-1]};
  assign w_div_resta   = w_div_parcial - {1'b0, b_q};
  assign w_div_paso    = w_div_resta[ANCHO]
                       ? {w_div_parcial[ANCHO-1:0], w_lo[ANCHO-2:0], 1'b0}
                       : {w_div_resta[ANCHO-1:0],   w_lo[ANCHO-2:0], 1'b1};
  assign w_paso        = w_es_mul ? w_mul_paso : w_div_paso;

  assign w_suma = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    w_err = 1'b0;
    w_val = '0;
    case (op_q)
      OP_SUMA: begin
        w_val = w_suma[ANCHO-1:0];
        w_err = w_suma[ANCHO];
      end
      OP_RESTA: begin
        w_val = a_q - b_q;
        w_err = (a_q < b_q);
      end
      OP_MUL: begin
        w_val = w_paso[ANCHO-1:0];
        w_err = |w_paso[2*ANCHO-1:ANCHO];
      end
      default: begin
        if (w_es_div) begin
          w_err = w_div_cero;
          w_val = w_es_mod ? w_paso[2*ANCHO-1:ANCHO] : w_paso[ANCHO-1:0];
        end else begin
          w_err = 1'b1;
        end
      end
    endcase
  end

  assign w_res_fin = w_err ? '0 : w_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_CALC;
      S_CALC:         if (w_fin)     state_d = S_DONE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ready_d = ready_q;
    error_d = error_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.datoA;
          b_d     = bus.datoB;
          op_d    = bus.operacion;
          cnt_d   = '0;
          res_d   = '0;
          ready_d = 1'b0;
          error_d = 1'b0;
          acc_d   = (bus.operacion == OP_MUL) ? {{ANCHO{1'b0}}, bus.datoB}
                                              : {{ANCHO{1'b0}}, bus.datoA};
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        acc_d = w_paso;
        if (w_fin) begin
          res_d   = w_res_fin;
          error_d = w_err;
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign bus.resultado = res_q;
  assign bus.ready     = ready_q;
  assign bus.error     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_unidad_aritmetica_seq.sv
// tb_unidad_aritmetica_seq: directed-vector bench for unidad_aritmetica_seq (ANCHO=32).
// Revision 1.0
`default_nettype none

module tb_unidad_aritmetica_seq;

`ifdef CALC_MODULO_EN
  localparam bit MOD_EN = 1'b1;
`else
  localparam bit MOD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  unidad_aritmetica_seq_if #(.ANCHO(32)) bus ();

  unidad_aritmetica_seq #(.ANCHO(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge clk);
    bus.datoA     = a;
    bus.datoB     = b;
    bus.operacion = op;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Returns the number of edges after the accepting edge at which ready was first seen.
  task automatic wait_ready(output int cyc);
    cyc = 1;
    @(posedge clk);
    #1;
    while (!bus.ready && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    n_chk++;
    if (bus.ready !== 1'b0 || bus.resultado !== 32'd0 || bus.error !== 1'b0)
      $display("FAIL reset_values: ready=%b res=%h err=%b, expected 0/0/0",
               bus.ready, bus.resultado, bus.error);
    else n_pass++;
  endtask

  task automatic test_suma_resta;
    logic [31:0] va [6] = '{32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd60, 32'd45, 32'd7};
    logic [31:0] vb [6] = '{32'd5,  32'd1,         32'd1,         32'd45, 32'd60, 32'd7};
    logic [2:0]  vo [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    logic [31:0] er [6] = '{32'd15, 32'd0, 32'hFFFF_FFFF, 32'd15, 32'd0, 32'd0};
    logic        ee [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vo[i]);
      wait_ready(cyc);
      n_chk++;
      if (cyc !== 1 || bus.resultado !== er[i] || bus.error !== ee[i])
        $display("FAIL sumres[%0d]: lat=%0d res=%h err=%b, expected lat=1 res=%h err=%b",
                 i, cyc, bus.resultado, bus.error, er[i], ee[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mul;
    logic [31:0] va [4] = '{32'd15, 32'h0001_0000, 32'h0000_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb [4] = '{32'd5,  32'h0001_0000, 32'h0000_FFFF, 32'd1};
    logic [31:0] er [4] = '{32'd75, 32'd0, 32'hFFFE_0001, 32'hFFFF_FFFF};
    logic        ee [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], 3'd2);
      wait_ready(cyc);
      n_chk++;
      if (cyc !== 32 || bus.resultado !== er[i] || bus.error !== ee[i])
        $display("FAIL mul[%0d]: lat=%0d res=%h err=%b, expected lat=32 res=%h err=%b",
                 i, cyc, bus.resultado, bus.error, er[i], ee[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div;
    logic [31:0] va [6] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'd5, 32'd100, 32'd100};
    logic [31:0] vb [6] = '{32'd7,   32'd0,   32'hFFFF_FFFF, 32'd9, 32'd7,   32'd0};
    logic [2:0]  vo [6] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4};
    logic [31:0] er [6] = '{32'd14, 32'd0, 32'd1, 32'd0, (MOD_EN ? 32'd2 : 32'd0), 32'd0};
    logic        ee [6] = '{1'b0, 1'b1, 1'b0, 1'b0, !MOD_EN, 1'b1};
    int          el [6] = '{32, 1, 32, 32, (MOD_EN ? 32 : 1), 1};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vo[i]);
      wait_ready(cyc);
      n_chk++;
      if (cyc !== el[i] || bus.resultado !== er[i] || bus.error !== ee[i])
        $display("FAIL div[%0d]: lat=%0d res=%h err=%b, expected lat=%0d res=%h err=%b",
                 i, cyc, bus.resultado, bus.error, el[i], er[i], ee[i]);
      else n_pass++;
    end
  endtask

  task automatic test_invalid;
    int cyc;
    for (int op = 5; op < 8; op++) begin
      issue(32'd3, 32'd4, 3'(op));
      wait_ready(cyc);
      n_chk++;
      if (cyc !== 1 || bus.resultado !== 32'd0 || bus.error !== 1'b1)
        $display("FAIL invalid_op%0d: lat=%0d res=%h err=%b, expected lat=1 res=0 err=1",
                 op, cyc, bus.resultado, bus.error);
      else n_pass++;
    end
  endtask

  task automatic test_no_effect;
    int lat = 0;
    issue(32'd15, 32'd5, 3'd2);
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready) lat = k;
      else if (k < 6) begin
        bus.datoA     = $urandom;
        bus.datoB     = $urandom;
        bus.operacion = 3'd0;
        bus.start     = 1'b1;
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    n_chk++;
    if (lat !== 32 || bus.resultado !== 32'd75 || bus.error !== 1'b0)
      $display("FAIL no_effect: lat=%0d res=%h err=%b, expected lat=32 res=0000004b err=0",
               lat, bus.resultado, bus.error);
    else n_pass++;
  endtask

  task automatic test_reset_async;
    int cyc;
    bit seen = 1'b0;
    issue(32'd10, 32'd5, 3'd0);
    wait_ready(cyc);
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.ready !== 1'b0 || bus.resultado !== 32'd0 || bus.error !== 1'b0)
      $display("FAIL reset_in_done: ready=%b res=%h err=%b, expected 0/0/0",
               bus.ready, bus.resultado, bus.error);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;

    issue(32'd15, 32'd5, 3'd2);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.ready !== 1'b0 || bus.resultado !== 32'd0 || bus.error !== 1'b0)
      $display("FAIL reset_mid_calc: ready=%b res=%h err=%b, expected 0/0/0",
               bus.ready, bus.resultado, bus.error);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ready) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0)
      $display("FAIL no_ready_after_reset: ready seen=%b, expected 0", seen);
    else n_pass++;

    issue(32'd100, 32'd7, 3'd3);
    wait_ready(cyc);
    n_chk++;
    if (cyc !== 32 || bus.resultado !== 32'd14 || bus.error !== 1'b0)
      $display("FAIL recover_after_reset: lat=%0d res=%h err=%b, expected lat=32 res=0000000e err=0",
               cyc, bus.resultado, bus.error);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic        exp_rdy;
    logic [31:0] exp_res;
    @(negedge clk);
    bus.datoA     = 32'd1;
    bus.datoB     = 32'd1;
    bus.operacion = 3'd0;
    bus.start     = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      exp_rdy = (k % 2 == 1);
      exp_res = exp_rdy ? 32'd2 : 32'd0;
      n_chk++;
      if (bus.ready !== exp_rdy || bus.resultado !== exp_res || bus.error !== 1'b0)
        $display("FAIL back_to_back[%0d]: ready=%b res=%h err=%b, expected ready=%b res=%h err=0",
                 k, bus.ready, bus.resultado, bus.error, exp_rdy, exp_res);
      else n_pass++;
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bus.datoA     = '0;
    bus.datoB     = '0;
    bus.operacion = '0;
    bus.start     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk) rst_n = 1'b1;
    test_suma_resta;
    test_mul;
    test_div;
    test_invalid;
    test_no_effect;
    test_reset_async;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
